// File: rtl/fpu_exec_unit_if.sv
// Request/response bundle between the FPU register bank and the execution unit.
// The bank drives through the master modport; the unit sits on the slave side.
interface fpu_exec_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] OP1;
  logic [DATA_WIDTH-1:0] OP2;
  logic [2:0]            OP_select;
  logic                  START;
  logic [DATA_WIDTH-1:0] RESULT;
  logic [3:0]            FLAGS;
  logic                  BUSY;
  logic                  DONE;

  modport master (output OP1, OP2, OP_select, START,
                  input  RESULT, FLAGS, BUSY, DONE);
  modport slave  (input  OP1, OP2, OP_select, START,
                  output RESULT, FLAGS, BUSY, DONE);
endinterface

// File: rtl/fpu_exec_unit.sv
// Binary32 execution unit: ADD/SUB/MUL/MIN/MAX through a fixed five-state
// sequence (IDLE, UNPACK, EXEC, NORM, DONE); denormals flush, results truncate.
module fpu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           CLK,
  input  logic           RSTN,
  fpu_exec_unit_if.slave bus
);
  localparam logic [2:0]  OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010,
                          OP_MIN = 3'b011, OP_MAX = 3'b100;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [30:0] INF  = 31'h7F80_0000;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_EXEC, S_NORM, S_DONE} state_t;
  state_t r_state, w_next;
  logic   w_busy, w_done;

  function automatic logic [5:0] lzc47(input logic [46:0] v);
    logic [5:0] n;
    n = 6'd47;
    for (int i = 0; i < 47; i++)
      if (v[i]) n = 6'(46 - i);
    return n;
  endfunction

  // Truncated mantissa plus exponent range saturation -> {flags, result}.
  function automatic logic [35:0] sat_pack(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] f);
    if (e >= 10'sd255)    return {4'b0100, s, INF};
    else if (e <= 10'sd0) return {4'b0010, s, 31'd0};
    else                  return {4'b0000, s, e[7:0], f};
  endfunction

  // Signed total order with -0 below +0, as an unsigned key.
  function automatic logic [31:0] ord_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) r_state <= S_IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:   begin w_busy = 1'b0; if (bus.START) w_next = S_UNPACK; end
      S_UNPACK: w_next = S_EXEC;
      S_EXEC:   w_next = S_NORM;
      S_NORM:   w_next = S_DONE;
      S_DONE:   begin w_done = 1'b1; w_next = S_IDLE; end
      default:  begin w_busy = 1'b0; w_next = S_IDLE; end
    endcase
  end

  assign bus.BUSY = w_busy;
  assign bus.DONE = w_done;

  // Capture: operands frozen for the whole operation
  logic [DATA_WIDTH-1:0] r_a_p0, r_b_p0;
  logic [2:0]            r_op_p0;
  always_ff @(posedge CLK)
    if (r_state == S_IDLE && bus.START) begin
      r_a_p0  <= bus.OP1;
      r_b_p0  <= bus.OP2;
      r_op_p0 <= bus.OP_select;
    end

  // UNPACK: fields split, hidden bit restored, denormals flushed to signed zero
  logic        r_sa_p1, r_sb_p1;
  logic [7:0]  r_ea_p1, r_eb_p1;
  logic [23:0] r_ma_p1, r_mb_p1;
  logic [2:0]  r_op_p1;
  always_ff @(posedge CLK)
    if (r_state == S_UNPACK) begin
      r_sa_p1 <= r_a_p0[31];
      r_sb_p1 <= r_b_p0[31];
      r_ea_p1 <= r_a_p0[30:23];
      r_eb_p1 <= r_b_p0[30:23];
      r_ma_p1 <= (r_a_p0[30:23] == 8'd0) ? 24'd0 : {1'b1, r_a_p0[22:0]};
      r_mb_p1 <= (r_b_p0[30:23] == 8'd0) ? 24'd0 : {1'b1, r_b_p0[22:0]};
      r_op_p1 <= r_op_p0;
    end

  // EXEC: special operands, aligned add/sub, mantissa product, min/max
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic        w_sbe, w_effsub, w_a_big, w_sl, w_a_lt;
  logic [7:0]  w_el, w_es, w_shamt;
  logic [23:0] w_ml, w_ms, w_ms_al;
  logic [24:0] w_sum;
  logic [47:0] w_prod;

  assign w_nan_a  = (r_ea_p1 == 8'hFF) && (r_ma_p1[22:0] != 23'd0);
  assign w_nan_b  = (r_eb_p1 == 8'hFF) && (r_mb_p1[22:0] != 23'd0);
  assign w_inf_a  = (r_ea_p1 == 8'hFF) && (r_ma_p1[22:0] == 23'd0);
  assign w_inf_b  = (r_eb_p1 == 8'hFF) && (r_mb_p1[22:0] == 23'd0);
  assign w_zero_a = (r_ma_p1 == 24'd0);
  assign w_zero_b = (r_mb_p1 == 24'd0);
  assign w_sbe    = r_sb_p1 ^ (r_op_p1 == OP_SUB);
  assign w_effsub = r_sa_p1 ^ w_sbe;
  assign w_a_big  = {r_ea_p1, r_ma_p1} >= {r_eb_p1, r_mb_p1};
  assign w_el     = w_a_big ? r_ea_p1 : r_eb_p1;
  assign w_es     = w_a_big ? r_eb_p1 : r_ea_p1;
  assign w_ml     = w_a_big ? r_ma_p1 : r_mb_p1;
  assign w_ms     = w_a_big ? r_mb_p1 : r_ma_p1;
  assign w_sl     = w_a_big ? r_sa_p1 : w_sbe;
  assign w_shamt  = w_el - w_es;
  assign w_ms_al  = (w_shamt >= 8'd25) ? 24'd0 : (w_ms >> w_shamt);
  assign w_sum    = w_effsub ? ({1'b0, w_ml} - {1'b0, w_ms_al}) : ({1'b0, w_ml} + {1'b0, w_ms_al});
  assign w_prod   = r_ma_p1 * r_mb_p1;
  assign w_a_lt   = ord_key(r_a_p0) < ord_key(r_b_p0);

  logic               w_spec, w_inv, w_sign;
  logic [31:0]        w_spec_res;
  logic signed [9:0]  w_exp;
  logic [47:0]        w_mant;
  always_comb begin
    w_spec = 1'b0; w_inv = 1'b0; w_sign = 1'b0;
    w_spec_res = 32'd0; w_exp = 10'sd0; w_mant = 48'd0;
    case (r_op_p1)
      OP_ADD, OP_SUB: begin
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && w_effsub)) begin
          w_spec = 1'b1; w_inv = 1'b1; w_spec_res = QNAN;
        end else if (w_inf_a) begin
          w_spec = 1'b1; w_spec_res = {r_sa_p1, INF};
        end else if (w_inf_b) begin
          w_spec = 1'b1; w_spec_res = {w_sbe, INF};
        end else begin
          w_sign = (w_effsub && w_sum == 25'd0) ? 1'b0 : w_sl;
          w_exp  = $signed({2'b00, w_el});
          w_mant = {w_sum, 23'd0};
        end
      end
      OP_MUL: begin
        if (w_nan_a || w_nan_b || ((w_inf_a || w_inf_b) && (w_zero_a || w_zero_b))) begin
          w_spec = 1'b1; w_inv = 1'b1; w_spec_res = QNAN;
        end else if (w_inf_a || w_inf_b) begin
          w_spec = 1'b1; w_spec_res = {r_sa_p1 ^ r_sb_p1, INF};
        end else begin
          w_sign = r_sa_p1 ^ r_sb_p1;
          w_exp  = $signed({2'b00, r_ea_p1}) + $signed({2'b00, r_eb_p1}) - 10'sd127;
          w_mant = w_prod;
        end
      end
      OP_MIN, OP_MAX: begin
        w_spec = 1'b1;
        if (w_nan_a || w_nan_b) begin
          w_inv = 1'b1; w_spec_res = QNAN;
        end else begin
          w_spec_res = ((r_op_p1 == OP_MIN) == w_a_lt) ? r_a_p0 : r_b_p0;
        end
      end
      default: begin
        w_spec = 1'b1; w_inv = 1'b1; w_spec_res = QNAN;
      end
    endcase
  end

  logic               r_spec_p2, r_inv_p2, r_sign_p2;
  logic [31:0]        r_spec_res_p2;
  logic signed [9:0]  r_exp_p2;
  logic [47:0]        r_mant_p2;
  always_ff @(posedge CLK)
    if (r_state == S_EXEC) begin
      r_spec_p2     <= w_spec;
      r_inv_p2      <= w_inv;
      r_spec_res_p2 <= w_spec_res;
      r_sign_p2     <= w_sign;
      r_exp_p2      <= w_exp;
      r_mant_p2     <= w_mant;
    end

  // NORM: carry right-shift or leading-zero left-shift, truncate, saturate
  logic [5:0]  w_lz;
  logic [47:0] w_sh;
  logic [35:0] w_pack;
  always_comb begin
    w_lz   = lzc47(r_mant_p2[46:0]);
    w_sh   = r_mant_p2 << w_lz;
    w_pack = 36'd0;
    if (r_spec_p2)               w_pack = {r_inv_p2, 3'b000, r_spec_res_p2};
    else if (r_mant_p2 == 48'd0) w_pack = {4'b0000, r_sign_p2, 31'd0};
    else if (r_mant_p2[47])      w_pack = sat_pack(r_sign_p2, r_exp_p2 + 10'sd1, r_mant_p2[46:24]);
    else                         w_pack = sat_pack(r_sign_p2, r_exp_p2 - $signed({4'd0, w_lz}), w_sh[45:23]);
    w_pack[32] = (w_pack[30:0] == 31'd0);
  end

  logic [DATA_WIDTH-1:0] r_result;
  logic [3:0]            r_flags;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      r_result <= '0;
      r_flags  <= 4'd0;
    end else if (r_state == S_NORM) begin
      r_flags  <= w_pack[35:32];
      r_result <= w_pack[31:0];
    end

  assign bus.RESULT = r_result;
  assign bus.FLAGS  = r_flags;
endmodule

// File: tb/tb_fpu_exec_unit.sv
// Bench for fpu_exec_unit: vector table through a scoreboard queue, plus
// hand-written sequences for mid-operation input changes and reset abort.
module tb_fpu_exec_unit;
  logic CLK = 1'b0;
  logic RSTN;
  always #5 CLK = ~CLK;

  fpu_exec_unit_if bus ();
  fpu_exec_unit #(.DATA_WIDTH(32)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic [3:0]  fl;
    int          mode;   // 0 plain, 1 change OP1 while busy, 2 extra START in UNPACK
  } vec_t;

  vec_t        vt[$];
  logic [35:0] sb[$];
  logic [35:0] mon_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  always @(negedge CLK)
    if (RSTN === 1'b1 && bus.DONE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 64'd1, 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("result_flags", {28'd0, bus.FLAGS, bus.RESULT}, {28'd0, mon_exp});
      end
    end

  task automatic issue(input vec_t v, input int idx);
    int done_cyc, busy_cnt, done_cnt;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge CLK);
    bus.OP1 = v.a; bus.OP2 = v.b; bus.OP_select = v.op; bus.START = 1'b1;
    sb.push_back({v.fl, v.res});
    done_cyc = 0; busy_cnt = 0; done_cnt = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge CLK);
      if (bus.BUSY) busy_cnt++;
      if (bus.DONE) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (cyc == 1) begin
        bus.START = (v.mode == 2);
        if (v.mode == 1) bus.OP1 = 32'h1234_5678;
      end else begin
        bus.START = 1'b0;
      end
    end
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'd4);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    bus.START = 1'b0; bus.OP1 = '0; bus.OP2 = '0; bus.OP_select = 3'd0;
    RSTN = 1'b1;
    #1 RSTN = 1'b0;
    #2 chk("reset_outputs", {26'd0, bus.RESULT, bus.FLAGS, bus.BUSY, bus.DONE}, 64'd0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;

    vt.push_back('{3'b000, 32'h3FC00000, 32'h40100000, 32'h40700000, 4'b0000, 0});
    vt.push_back('{3'b010, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 1});
    vt.push_back('{3'b001, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0001, 2});
    vt.push_back('{3'b010, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, 0});
    vt.push_back('{3'b010, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 0});
    vt.push_back('{3'b000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 0});
    vt.push_back('{3'b110, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 4'b1000, 0});
    vt.push_back('{3'b101, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0});
    vt.push_back('{3'b111, 32'h40000000, 32'h40000000, 32'h7FC00000, 4'b1000, 0});
    vt.push_back('{3'b011, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0001, 0});
    vt.push_back('{3'b100, 32'h80000000, 32'h00000000, 32'h00000000, 4'b0001, 0});
    vt.push_back('{3'b011, 32'h3F800000, 32'hBF800000, 32'hBF800000, 4'b0000, 0});
    vt.push_back('{3'b100, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 0});
    vt.push_back('{3'b001, 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000, 0});
    vt.push_back('{3'b000, 32'h3F800000, 32'hBF000000, 32'h3F000000, 4'b0000, 0});
    vt.push_back('{3'b000, 32'h3F800000, 32'h3FC00000, 32'h40200000, 4'b0000, 0});
    vt.push_back('{3'b000, 32'h3F800000, 32'h00000001, 32'h3F800000, 4'b0000, 0});
    vt.push_back('{3'b000, 32'h4B800000, 32'h3F800000, 32'h4B800000, 4'b0000, 0});
    vt.push_back('{3'b000, 32'h4C000000, 32'h3F800000, 32'h4C000000, 4'b0000, 0});
    vt.push_back('{3'b010, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 0});
    vt.push_back('{3'b010, 32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 0});
    vt.push_back('{3'b000, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 0});
    vt.push_back('{3'b010, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 0});
    vt.push_back('{3'b010, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0000, 0});

    foreach (vt[i]) issue(vt[i], i);

    // Reset pulsed while the operation sits in EXEC: no DONE may follow.
    @(negedge CLK);
    bus.OP1 = 32'h3F800000; bus.OP2 = 32'h3F800000; bus.OP_select = 3'b000; bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
    #2 RSTN = 1'b0;
    #1 chk("abort_outputs", {26'd0, bus.RESULT, bus.FLAGS, bus.BUSY, bus.DONE}, 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (bus.DONE) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);

    issue('{3'b000, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 0}, 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_exec_unit.md
FPU_EXEC_UNIT -- requirements
Module: fpu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width; only 32 (IEEE-754 binary32) is supported.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port OP1  input  32  operand A, from the FPU register bank.
REQ-005 SHALL have port OP2  input  32  operand B, from the FPU register bank.
REQ-006 SHALL have port OP_select  input  3  operation code, from the register bank.
REQ-007 SHALL have port START  input  1  one-cycle request to begin an operation.
REQ-008 SHALL have port RESULT  output  32  binary32 result, held until the next completion.
REQ-009 SHALL have port FLAGS  output  4  sticky-free status {invalid, overflow, underflow, zero}, bits [3:0] in that order.
REQ-010 SHALL have port BUSY  output  1  high while an operation is in flight.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse when RESULT and FLAGS update.

Function
REQ-012 SHALL decode OP_select as 000 ADD, 001 SUB (A-B), 010 MUL, 011 MIN, 100 MAX; codes 101-111 SHALL give RESULT 0x7FC00000 with invalid=1.
REQ-013 SHALL implement an FSM with states IDLE, UNPACK, EXEC, NORM, DONE, advancing one state per clock in that order and returning DONE->IDLE unconditionally.
REQ-014 SHALL accept START only in IDLE; in that cycle it SHALL capture OP1, OP2 and OP_select into internal registers. Later input changes SHALL not affect the operation.
REQ-015 SHALL ignore START while BUSY=1, with no queuing.
REQ-016 SHALL assert BUSY from the cycle after START through the DONE state inclusive.
REQ-017 SHALL give fixed latency: DONE pulses high exactly 4 clocks after the START edge, and RESULT/FLAGS are valid in that same cycle.
REQ-018 UNPACK SHALL split sign, exponent and 24-bit mantissa (hidden bit restored) and flush denormal inputs to signed zero.
REQ-019 EXEC ADD/SUB SHALL align the smaller-exponent mantissa by right shift, with shift amounts of 25 or more giving 0. It SHALL then add or subtract with 1 carry bit.
REQ-020 EXEC MUL SHALL form the 48-bit mantissa product, set exponent to eA+eB-127, and set sign to sA^sB.
REQ-021 NORM SHALL normalize by leading-zero left shift or by a 1-bit right shift on carry, and SHALL round toward zero (truncate).
REQ-022 A biased exponent of 255 or more after NORM SHALL give signed Inf with overflow=1.
REQ-023 A biased exponent of 0 or less after NORM SHALL give signed zero with underflow=1.
REQ-024 An exact-zero difference SHALL give +0.
REQ-025 Any NaN input, Inf-Inf (effective subtraction) or 0*Inf SHALL give 0x7FC00000 with invalid=1.
REQ-026 Other Inf operands SHALL propagate as signed Inf with no flag.
REQ-027 MIN/MAX SHALL compare signed values with -0 < +0. A NaN input to MIN/MAX SHALL give invalid=1 and RESULT 0x7FC00000.
REQ-028 FLAGS.zero SHALL equal 1 whenever RESULT[30:0]==0.
REQ-029 FLAGS SHALL be recomputed on every completion; no flag SHALL be sticky.

Reset
REQ-030 RSTN low SHALL force IDLE and set RESULT=0, FLAGS=0, BUSY=0, DONE=0 immediately, independent of CLK.
REQ-031 A reset mid-operation SHALL abort the operation with no DONE pulse. The first START after RSTN deasserts SHALL behave per REQ-014.

Verification
REQ-032 SHALL cover: ADD 0x3FC00000+0x40100000 -> RESULT 0x40700000, FLAGS 0000, DONE exactly 4 clocks after START, BUSY high for 4 cycles.
REQ-033 SHALL cover: MUL 0x40000000*0x40400000 -> 0x40C00000; the bench changes OP1 during BUSY and the result is unaffected.
REQ-034 SHALL cover: SUB 0x3F800000-0x3F800000 -> 0x00000000, zero=1. A second START is issued in the UNPACK cycle and is ignored (one DONE only).
REQ-035 SHALL cover: MUL 0x7F000000*0x7F000000 -> 0x7F800000, overflow=1. MUL 0x00800000*0x00800000 -> 0x00000000, underflow=1 and zero=1.
REQ-036 SHALL cover: ADD 0x7F800000+0xFF800000 -> 0x7FC00000, invalid=1. OP_select=110 -> 0x7FC00000, invalid=1. MIN 0x80000000,0x00000000 -> 0x80000000.
REQ-037 SHALL cover: RSTN pulsed low during EXEC -> outputs 0 immediately, no DONE. A following ADD 0x3F800000+0x3F800000 -> 0x40000000.
